// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: note code ranges, the
// half-period table (in divider ticks) and the display decode.
package tone_pkg;

   localparam int NOTE_W = 5;
   localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
   localparam logic [NOTE_W-1:0] NOTE_MAX  = 5'd21;

   typedef logic [10:0] half_t;

   // Half period of each note in ticks; index 0 is rest.
   localparam half_t HALF_TAB [0:21] = '{
      11'd0,
      11'd1911, 11'd1703, 11'd1517, 11'd1432, 11'd1276, 11'd1136, 11'd1012,
      11'd956,  11'd851,  11'd758,  11'd716,  11'd638,  11'd568,  11'd506,
      11'd478,  11'd426,  11'd379,  11'd358,  11'd319,  11'd284,  11'd253
   };

   typedef struct packed {
      logic [3:0] code;
      logic [1:0] high;
   } disp_t;

   function automatic logic is_tone(input logic [NOTE_W-1:0] n);
      return (n != NOTE_REST) && (n <= NOTE_MAX);
   endfunction

   // Digit within the octave plus octave flag; codes above NOTE_MAX are rest.
   function automatic disp_t note_decode(input logic [NOTE_W-1:0] n);
      disp_t d;
      d = '0;
      if (!is_tone(n)) begin
         d = '0;
      end else if (n <= 5'd7) begin
         d.code = 4'(n);
         d.high = 2'b01;
      end else if (n <= 5'd14) begin
         d.code = 4'(n - 5'd7);
         d.high = 2'b10;
      end else begin
         d.code = 4'(n - 5'd14);
         d.high = 2'b11;
      end
      return d;
   endfunction

endpackage

// File: rtl/tone_tick_div.sv
// Prescaler: one tick pulse every PRE_DIV clock cycles while enabled.
module tone_tick_div #(
   parameter int PRE_DIV = 12
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   output logic tick
);

   localparam int CW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..PRE_DIV-1, held at 0 while disabled or in reset.
   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = EN && (cnt == LAST);

endmodule

// File: rtl/tone_gen.sv
// Speaker tone generator: registers the ROM note code, divides the tick
// stream by the note's half period to make a square wave, and decodes
// the note for the display stage. The half counter is only reloaded at
// a waveform boundary, so a note change never produces a runt pulse.
module tone_gen
   import tone_pkg::*;
#(
   parameter int PRE_DIV = 12,
   parameter int HALF_W  = 11
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [NOTE_W-1:0] NOTE,
   output logic              SPKOUT,
   output logic [3:0]        CODE,
   output logic [1:0]        HIGH
);

   logic [NOTE_W-1:0] note_q;
   logic [NOTE_W-1:0] cur_note;
   logic [HALF_W-1:0] hcnt;
   logic              tick;
   disp_t             disp_d;

   tone_tick_div #(.PRE_DIV(PRE_DIV)) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .tick (tick)
   );

   // Input register: note_q follows NOTE every cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         note_q <= '0;
      end else begin
         note_q <= NOTE;
      end
   end

   assign disp_d = note_decode(note_q);

   // Registered display decode; keeps tracking NOTE even while EN is low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         CODE <= '0;
         HIGH <= '0;
      end else begin
         CODE <= disp_d.code;
         HIGH <= disp_d.high;
      end
   end

   // Half-period divider: count down on ticks, and at a boundary (hcnt==0)
   // adopt note_q, reload its half period and toggle or silence the output.
   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         hcnt     <= '0;
         cur_note <= '0;
         SPKOUT   <= 1'b0;
      end else if (tick) begin
         if (hcnt != '0) begin
            // hcnt is only nonzero while a tone is playing.
            if (is_tone(cur_note)) begin
               hcnt <= hcnt - 1'b1;
            end else begin
               hcnt <= '0;
            end
         end else begin
            cur_note <= note_q;
            if (is_tone(note_q)) begin
               hcnt   <= HALF_W'(HALF_TAB[note_q] - 1'b1);
               SPKOUT <= ~SPKOUT;
            end else begin
               hcnt   <= '0;
               SPKOUT <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream neighbour of the note-ROM address counter: consumes the 5-bit note code read from the note ROM at each address and drives the speaker square wave.
- Also produces the display digit and octave flags for the 7-segment and LED stage.
- Contains a tick prescaler, a glitch-free half-period divider reloaded only at waveform boundaries, and registered decode outputs.

Parameters:
- PRE_DIV, 12, CLK cycles per divider tick (12 MHz CLK gives a 1 MHz tick); legal range 1..255.
- HALF_W, 11, width of the half-period counter; must hold the largest table entry, 1911.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  play enable; low silences the output and holds the divider idle.
- NOTE  in  5  note code from the ROM: 0 = rest; 1-7 = low C..B; 8-14 = mid C..B; 15-21 = high C..B; 22-31 = rest.
- SPKOUT  out  1  speaker square wave.
- CODE  out  4  display digit: 1-7 for the note within its octave, 0 for rest.
- HIGH  out  2  octave flag: 00 rest, 01 low, 10 mid, 11 high.

Behaviour:
- Reset, and every cycle with RST=1: SPKOUT=0, CODE=0, HIGH=00, prescaler=0, half counter=0, current note=0, note_q=0.
- Input register:
  - NOTE is registered into note_q every cycle.
  - CODE and HIGH are registered decodes of note_q, so they follow NOTE with 2 cycles of latency.
  - Codes 22-31 decode as rest.
- Prescaler:
  - Counts 0..PRE_DIV-1 while EN=1.
  - tick=1 in the cycle the count equals PRE_DIV-1; the count then wraps to 0.
  - With PRE_DIV=1, tick=1 every cycle.
- Half-period table (ticks, from the shared package):
  - Low: 1911 1703 1517 1432 1276 1136 1012
  - Mid: 956 851 758 716 638 568 506
  - High: 478 426 379 358 319 284 253
  - Rest: 0
- Divider, acting only on tick cycles:
  - hcnt != 0: decrement hcnt.
  - hcnt == 0 (boundary):
    - Latch cur_note <= note_q.
    - Load hcnt <= HALF(note_q) - 1 for a tone, or 0 for rest.
    - If note_q is a tone, toggle SPKOUT; otherwise force SPKOUT=0.
- A note change therefore takes effect only at a half-period boundary, so there are no runt pulses.
- While resting, hcnt stays 0, so every tick is a boundary: a new tone starts at the first tick after it appears in note_q, and its first edge is 0->1.
- Output period is 2*HALF*PRE_DIV CLK cycles.
- Same note across boundaries: a continuous wave, with no phase reset.
- Tone to rest: SPKOUT completes the current half period, then goes 0 and stays 0.
- EN=0 (synchronous, takes effect the next cycle):
  - SPKOUT=0, hcnt=0, prescaler=0, cur_note=0.
  - CODE and HIGH keep tracking NOTE.
- EN rising: behaves exactly like a start from rest.
- RST asserted mid-tone: every register returns to its reset value on that edge. After release, playback restarts exactly as from power-up.
- Simultaneous boundary and NOTE change in the same cycle: the boundary uses the old note_q. The new code is picked up at the following boundary.

Decomposition:
- Package tone_pkg holds:
  - NOTE_W=5, NOTE_REST=0, NOTE_MAX=21.
  - The 22-entry HALF_TAB constant (index 0 = 0).
  - The CODE and HIGH decode function, or its constants.
- Sub-module tone_tick_div: the PRE_DIV prescaler with EN and synchronous reset, producing the tick pulse.
- The top level holds the note register, the half counter, the SPKOUT toggle logic, and the display decode.

Test Plan:
- RST=1 for 3 cycles with NOTE=13 and EN=1 -> SPKOUT=0, CODE=0, HIGH=00 throughout reset. After release, CODE=6 and HIGH=10 two cycles later.
- PRE_DIV=12, EN=1, NOTE=13 (mid A) held -> SPKOUT high and low phases are each 6816 CLK cycles (13632-cycle period), with the first edge rising.
- PRE_DIV=2, NOTE switched from 1 (1911) to 21 (253) mid half-period -> the current 3822-cycle phase completes unchanged, then the phases become 506 cycles, with no shorter pulse in between.
- PRE_DIV=2, NOTE=8 then NOTE=0 -> the current 1912-cycle phase finishes, then SPKOUT=0 permanently and CODE=0. NOTE=25 gives the same result, with HIGH=00.
- EN dropped mid-phase with NOTE=15 -> SPKOUT=0 on the next cycle. On EN re-raise, the first rising edge appears PRE_DIV+2 cycles or fewer later, followed by 478*PRE_DIV-cycle phases.
- RST pulsed for 1 cycle mid-tone (NOTE=10) -> all outputs zero on that edge. Afterwards, phases are 758*PRE_DIV cycles, matching the startup timing.
